// File: rtl/fix2tfp_stream.sv
// rtl/fix2tfp_stream.sv - unsigned fixed-point to trivial float-point lane converter with a stallable pipeline
//
// Converts CHANNELS unsigned fixed-point lanes into {exp, mant} float-point
// words. Conversion happens ahead of the first register. PIPELINE register
// stages with bubble collapsing carry the result to the output.
//
// Ports:
//   clk        - the only clock
//   rst_n      - asynchronous active-low reset
//   clkena     - clock enable; low freezes every register and blocks both handshakes
//   inp_valid  - input word set valid
//   inp_ready  - block accepts input (combinational from out_ready)
//   inp_data   - CHANNELS lanes of FIX_WIDTH bits, lane k at [k*FIX_WIDTH +: FIX_WIDTH]
//   out_valid  - output word set valid (last-stage valid bit)
//   out_ready  - downstream accepts output
//   out_data   - CHANNELS lanes of TFP_WIDTH bits, lane k = {exp, mant}
//   out_sat    - per-lane flag: rounding saturated that lane
//   sat_count  - saturating count of output transfers with any out_sat bit set
module fix2tfp_stream #(
  parameter int TFP_WIDTH = 8,
  parameter int EXP_WIDTH = 3,
  parameter int CHANNELS  = 2,
  parameter int PIPELINE  = 2,
  parameter int ROUND     = 0,
  localparam int M         = TFP_WIDTH - EXP_WIDTH,
  localparam int FIX_WIDTH = M + 2**EXP_WIDTH - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clkena,
  input  logic                          inp_valid,
  output logic                          inp_ready,
  input  logic [CHANNELS*FIX_WIDTH-1:0] inp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*TFP_WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]           out_sat,
  output logic [15:0]                   sat_count
);

  localparam int EMAX = 2**EXP_WIDTH - 1;
  localparam int DW   = CHANNELS * TFP_WIDTH;

  // Returns {sat, exp, mant} for one lane.
  function automatic logic [TFP_WIDTH:0] convert(input logic [FIX_WIDTH-1:0] fix);
    logic [EXP_WIDTH-1:0] e;
    logic [FIX_WIDTH:0]   ext;
    logic [M:0]           mr;
    logic [M-1:0]         mant;
    logic                 sat;
    // Scan from the largest shift down so the last hit is the smallest exponent.
    e = '0;
    for (int i = EMAX; i >= 0; i--) begin
      if ((fix >> i) < FIX_WIDTH'(2**M)) e = EXP_WIDTH'(i);
    end
    // A zero appended below the LSB makes bit 0 of the shifted value the
    // first dropped bit, and exactly 0 when nothing is shifted out.
    ext = {fix, 1'b0} >> e;
    mr  = (M+1)'(ext >> 1);
    if (ROUND == 1) mr = mr + {{M{1'b0}}, ext[0]};
    sat  = 1'b0;
    mant = mr[M-1:0];
    if (mr[M]) begin
      if (e == EXP_WIDTH'(EMAX)) begin
        mant = '1;
        sat  = 1'b1;
      end else begin
        mant      = '0;
        mant[M-1] = 1'b1;
        e         = e + EXP_WIDTH'(1);
      end
    end
    return {sat, e, mant};
  endfunction

  logic [DW-1:0]       conv_data;
  logic [CHANNELS-1:0] conv_sat;

  always_comb begin
    conv_data = '0;
    conv_sat  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      {conv_sat[k], conv_data[k*TFP_WIDTH +: TFP_WIDTH]} =
        convert(inp_data[k*FIX_WIDTH +: FIX_WIDTH]);
    end
  end

  logic [PIPELINE-1:0] stg_valid;
  logic [DW-1:0]       stg_data [PIPELINE];
  logic [CHANNELS-1:0] stg_sat  [PIPELINE];

  logic [PIPELINE-1:0] stg_load;
  logic [PIPELINE-1:0] up_valid;
  logic [DW-1:0]       up_data  [PIPELINE];
  logic [CHANNELS-1:0] up_sat   [PIPELINE];
  logic                room;

  // A stage may load when any stage at or below it is empty, or when the
  // whole downstream chain is full and draining through out_ready.
  always_comb begin
    stg_load = '0;
    room     = out_ready;
    for (int i = PIPELINE - 1; i >= 0; i--) begin
      room        = room | ~stg_valid[i];
      stg_load[i] = room;
    end
  end

  always_comb begin
    up_valid    = '0;
    up_valid[0] = inp_valid;
    up_data[0]  = conv_data;
    up_sat[0]   = conv_sat;
    for (int i = 1; i < PIPELINE; i++) begin
      up_valid[i] = stg_valid[i-1];
      up_data[i]  = stg_data[i-1];
      up_sat[i]   = stg_sat[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      for (int i = 0; i < PIPELINE; i++) begin
        stg_data[i] <= '0;
        stg_sat[i]  <= '0;
      end
    end else if (clkena) begin
      for (int i = 0; i < PIPELINE; i++) begin
        if (stg_load[i]) begin
          stg_valid[i] <= up_valid[i];
          stg_data[i]  <= up_data[i];
          stg_sat[i]   <= up_sat[i];
        end
      end
    end
  end

  assign inp_ready = clkena & stg_load[0];
  assign out_valid = stg_valid[PIPELINE-1];
  assign out_data  = stg_data[PIPELINE-1];
  assign out_sat   = stg_sat[PIPELINE-1];

  logic out_xfer;
  assign out_xfer = clkena & out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (out_xfer && (|out_sat) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fix2tfp_stream.sv
// tb/tb_fix2tfp_stream.sv - self-checking bench for fix2tfp_stream (truncating and rounding instances)
module tb_fix2tfp_stream;

  localparam int M    = 5;
  localparam int EMAX = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clkena;
  logic        inp_valid;
  logic [23:0] inp_data;
  logic        out_ready;

  logic        r0_inp_ready, r1_inp_ready;
  logic        r0_out_valid, r1_out_valid;
  logic [15:0] r0_out_data, r1_out_data;
  logic [1:0]  r0_out_sat, r1_out_sat;
  logic [15:0] r0_sat_count, r1_sat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fix2tfp_stream #(.ROUND(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .clkena(clkena),
    .inp_valid(inp_valid), .inp_ready(r0_inp_ready), .inp_data(inp_data),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_data(r0_out_data),
    .out_sat(r0_out_sat), .sat_count(r0_sat_count)
  );

  fix2tfp_stream #(.ROUND(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clkena(clkena),
    .inp_valid(inp_valid), .inp_ready(r1_inp_ready), .inp_data(inp_data),
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
    .out_sat(r1_out_sat), .sat_count(r1_sat_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: smallest exponent that fits, then round by adding half an
  // LSB of the kept field before shifting.
  function automatic logic [8:0] ref_conv(input int fix, input int rnd);
    int e, mant;
    logic sat;
    logic [8:0] r;
    e   = 0;
    sat = 1'b0;
    while ((fix >> e) >= (1 << M)) e++;
    mant = fix >> e;
    if (rnd != 0 && e > 0) begin
      mant = (fix + (1 << (e - 1))) >> e;
      if (mant == (1 << M)) begin
        if (e == EMAX) begin
          mant = (1 << M) - 1;
          sat  = 1'b1;
        end else begin
          e++;
          mant = mant >> 1;
        end
      end
    end
    r = {sat, e[2:0], mant[4:0]};
    return r;
  endfunction

  function automatic logic [17:0] ref_word(input logic [23:0] d, input int rnd);
    logic [8:0] a, b;
    a = ref_conv(int'(d[11:0]), rnd);
    b = ref_conv(int'(d[23:12]), rnd);
    return {b[8], a[8], b[7:0], a[7:0]};
  endfunction

  // Scoreboard: expected words queued at input transfers, popped at output transfers.
  logic [17:0] q0[$];
  logic [17:0] q1[$];
  logic [15:0] msat = 16'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      msat = 16'd0;
    end else begin
      chk("sat_count_r1", 32'(r1_sat_count), 32'(msat));
      chk("sat_count_r0", 32'(r0_sat_count), 32'd0);
      if (r0_out_valid && out_ready && clkena) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_r0_spurious actual=%0h required=none", r0_out_data);
        end else begin
          logic [17:0] e0;
          e0 = q0.pop_front();
          chk("out_r0", {14'd0, r0_out_sat, r0_out_data}, {14'd0, e0});
        end
      end
      if (r1_out_valid && out_ready && clkena) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_r1_spurious actual=%0h required=none", r1_out_data);
        end else begin
          logic [17:0] e1;
          e1 = q1.pop_front();
          chk("out_r1", {14'd0, r1_out_sat, r1_out_data}, {14'd0, e1});
          if ((e1[17:16] != 2'b00) && msat != 16'hFFFF) msat = msat + 16'd1;
        end
      end
      if (inp_valid && r0_inp_ready) q0.push_back(ref_word(inp_data, 0));
      if (inp_valid && r1_inp_ready) q1.push_back(ref_word(inp_data, 1));
    end
  end

  typedef struct {
    logic [11:0] fix;
    logic [7:0]  t0;
    logic [7:0]  t1;
    logic        s1;
  } vec_t;

  vec_t vecs[11];

  task automatic randomize_ctl();
    clkena    = ($urandom_range(0, 4) != 0);
    out_ready = ($urandom_range(0, 4) > 1);
  endtask

  // Presents one word and holds it until it transfers, bounded.
  task automatic send(input logic [23:0] d, input bit rnd);
    bit got;
    got       = 1'b0;
    inp_data  = d;
    inp_valid = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = inp_valid && r0_inp_ready;
      @(posedge clk);
      #1;
      if (rnd) randomize_ctl();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=stalled required=transfer data=%0h", d);
    end
  endtask

  task automatic run_vec(input vec_t v);
    inp_data  = {v.fix, v.fix};
    inp_valid = 1'b1;
    @(negedge clk);
    chk("vec_inp_ready", 32'(r0_inp_ready), 32'd1);
    @(posedge clk);
    #1 inp_valid = 1'b0;
    @(negedge clk);
    chk("vec_latency_early", 32'(r0_out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("vec_out_valid", 32'(r1_out_valid), 32'd1);
    chk("vec_data_r0", 32'(r0_out_data), 32'({v.t0, v.t0}));
    chk("vec_data_r1", 32'(r1_out_data), 32'({v.t1, v.t1}));
    chk("vec_sat_r0", 32'(r0_out_sat), 32'd0);
    chk("vec_sat_r1", 32'(r1_out_sat), 32'({v.s1, v.s1}));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    inp_valid = 1'b0;
    clkena    = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (q0.size() + q1.size()) != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk(name, 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] hold0, hold1;
    int nsat;

    vecs[0]  = '{12'h013, 8'h13, 8'h13, 1'b0};
    vecs[1]  = '{12'h05F, 8'h57, 8'h58, 1'b0};
    vecs[2]  = '{12'h03F, 8'h3F, 8'h50, 1'b0};
    vecs[3]  = '{12'hFFF, 8'hFF, 8'hFF, 1'b1};
    vecs[4]  = '{12'h000, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{12'h020, 8'h30, 8'h30, 1'b0};
    vecs[6]  = '{12'h021, 8'h30, 8'h31, 1'b0};
    vecs[7]  = '{12'h7FF, 8'hDF, 8'hF0, 1'b0};
    vecs[8]  = '{12'hF80, 8'hFF, 8'hFF, 1'b0};
    vecs[9]  = '{12'hFC0, 8'hFF, 8'hFF, 1'b1};
    vecs[10] = '{12'h040, 8'h50, 8'h50, 1'b0};

    rst_n     = 1'b0;
    clkena    = 1'b1;
    out_ready = 1'b1;
    inp_valid = 1'b0;
    inp_data  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(r0_out_valid | r1_out_valid), 32'd0);
    chk("rst_out_data", 32'({r0_out_data, r1_out_data}), 32'd0);
    chk("rst_out_sat", 32'({r0_out_sat, r1_out_sat}), 32'd0);
    chk("rst_sat_count", 32'(r1_sat_count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table with exact-latency checks.
    nsat = 0;
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      nsat += int'(vecs[i].s1);
    end
    @(negedge clk);
    chk("sat_count_table", 32'(r1_sat_count), 32'(nsat));
    @(posedge clk);
    #1;

    // Back-pressure fill, hold, then clock-enable freeze.
    out_ready = 1'b0;
    send({12'h05F, 12'h05F}, 1'b0);
    send({12'h03F, 12'h021}, 1'b0);
    inp_data  = {12'h013, 12'h7FF};
    inp_valid = 1'b1;
    hold0 = ref_word({12'h05F, 12'h05F}, 0);
    hold1 = ref_word({12'h05F, 12'h05F}, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_inp_ready", 32'(r0_inp_ready), 32'd0);
      chk("stall_out_valid", 32'(r0_out_valid), 32'd1);
      chk("stall_data_r0", 32'(r0_out_data), 32'(hold0[15:0]));
      chk("stall_data_r1", 32'(r1_out_data), 32'(hold1[15:0]));
    end
    @(posedge clk);
    #1;
    clkena    = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("freeze_inp_ready", 32'(r0_inp_ready | r1_inp_ready), 32'd0);
      chk("freeze_out_valid", 32'(r1_out_valid), 32'd1);
      chk("freeze_data_r1", 32'(r1_out_data), 32'(hold1[15:0]));
      chk("freeze_sat_count", 32'(r1_sat_count), 32'(nsat));
      @(posedge clk);
      #1;
    end
    clkena = 1'b1;
    send({12'h013, 12'h7FF}, 1'b0);
    drain("stall_drain");

    // Reset in the middle of a full pipeline.
    out_ready = 1'b0;
    send({12'hFFF, 12'hFFF}, 1'b0);
    send({12'hFFF, 12'h05F}, 1'b0);
    inp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(r0_out_valid | r1_out_valid), 32'd0);
    chk("midrst_sat_count", 32'(r1_sat_count), 32'd0);
    chk("midrst_out_sat", 32'(r1_out_sat), 32'd0);
    chk("midrst_out_data", 32'(r1_out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("restart_inp_ready", 32'(r0_inp_ready), 32'd1);
    @(posedge clk);
    #1;
    send({12'hFFF, 12'h013}, 1'b0);
    drain("restart_drain");

    // Exhaustive lane sweep under random enable and back-pressure.
    for (int i = 0; i < 4096; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        inp_valid = 1'b0;
        @(posedge clk);
        #1 randomize_ctl();
      end
      send({12'(4095 - i), 12'(i)}, 1'b1);
    end
    drain("sweep_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
